demux8_3_reg: RTL
=================

// Module: demux8_3_reg
// PURPOSE
//   Registered 1-to-8 distributor, the write side of the 8:1 select mux. One valid/ready
//   source stream carries a 3-bit destination select. Each beat is steered into one of 8
//   one-entry output slots. Each slot drains on its own valid/ready handshake.
//   Used to fan a single result bus out to 8 consumers (register ports, units).
// PARAMETERS
//   W        32   data width of each beat
// PORTS
//   clk        in   1     single clock; all state changes on posedge
//   rst        in   1     asynchronous, active-high reset
//   in_valid   in   1     source beat present
//   in_ready   out  1     slot addressed by in_sel can accept this cycle
//   in_sel     in   3     destination channel 0..7
//   in_data    in   W     beat payload
//   out_valid  out  8     bit i: slot i holds a beat
//   out_ready  in   8     bit i: consumer i accepts slot i this cycle
//   out_data   out  8*W   slot i payload at [i*W +: W]
//   stat_cnt   out  8*16  (DEMUX8_STATS_EN only) delivered-beat count per channel
// BEHAVIOUR
//   - Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, stat_cnt=0.
//   - Per-slot 2-state FSM. EMPTY->FULL on load. FULL->EMPTY on drain without load.
//     FULL->FULL on simultaneous drain+load, and the slot takes the new data.
//   - drain_i = out_valid[i] & out_ready[i]; load_i = in_valid & in_ready & (in_sel==i).
//   - in_ready = ~out_valid[in_sel] | out_ready[in_sel]. Pass-through at full throughput.
//     in_ready is combinational from in_sel and out_ready; no path from in_valid.
//   - Latency: beat accepted at edge k appears on out_valid/out_data after edge k.
//     One cycle; no combinational in->out data path.
//   - out_data[i] holds stable while out_valid[i]=1 and not drained (AXI-style rule).
//   - Slots are independent. A stalled channel never blocks beats to other channels.
//     Only a beat aimed at a full, non-draining slot sees in_ready=0.
//   - Source must hold in_sel/in_data stable while in_valid=1 & in_ready=0.
//   - in_valid=0: no slot loads regardless of in_sel. out_ready on an empty slot is ignored.
//   - Reset mid-transfer discards all held beats. No beat is delivered twice.
// CONFIGURATION
//   - `DEMUX8_STATS_EN defined: stat_cnt port exists.
//     Counter i increments on each drain_i and wraps 16'hFFFF -> 16'h0000.
//   - Not defined: no stat_cnt port, no counter flops. Datapath behaviour is identical.
// STRUCTURE
//   - Shared header/package: N_CH=8, SEL_W=3, STAT_W=16, slot state encodings
//     SLOT_EMPTY=1'b0 and SLOT_FULL=1'b1.
//   - Sub-module demux_slot (one-entry W-bit register slot with load/drain and valid flag),
//     instantiated 8 times with a generate loop.
//   - Top holds select decode, in_ready mux and optional counters.
// TESTING
//   1. Reset, then send in_sel=3, data=32'hDEADBEEF with out_ready=0 ->
//      out_valid=8'h08 next cycle, out_data[3]=DEADBEEF; in_ready stays 1 for sel!=3.
//   2. Slot 3 full and out_ready[3]=0, send to sel=3 -> in_ready=0, data held.
//      Raise out_ready[3] -> same-cycle accept, slot 3 holds the new beat.
//   3. Stream 8 beats sel=0..7, data=i, all out_ready=1 ->
//      one beat per cycle, each channel i sees data i exactly once.
//   4. Slot 5 stalled full; send beats to sel=2 ->
//      in_ready=1, channel 2 unaffected, channel 5 data unchanged.
//   5. Load slots 1 and 6, assert rst mid-cycle -> out_valid=0 immediately (async).
//      No deliveries after release.
//   6. (DEMUX8_STATS_EN) 65537 drains on channel 7 -> stat_cnt[7]=1; other counters 0.

Source files
------------

// File: rtl/demux8_3_reg_pkg.sv
// Shared definitions for the registered 1-to-8 distributor.
//   N_CH   : number of output channels
//   SEL_W  : width of the destination select
//   STAT_W : width of each per-channel delivered-beat counter
//   slot_state_t : per-slot occupancy state
package demux8_3_reg_pkg;

    localparam int unsigned N_CH   = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned STAT_W = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux8_3_reg_slot.sv
// demux_slot: one-entry W-bit register slot with valid/ready drain.
//   clk   in   clock
//   rst   in   asynchronous active-high reset
//   load  in   write din into the slot this cycle
//   ready in   consumer accepts the held beat this cycle
//   din   in   W-bit payload to load
//   valid out  slot holds a beat
//   dout  out  held payload, stable until drained or reloaded
module demux_slot
    import demux8_3_reg_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         ready,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    slot_state_t state, state_nxt;
    logic        drain;

    assign valid = (state == SLOT_FULL);
    assign drain = valid & ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Simultaneous drain and load keeps the slot full with the new beat.
    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_EMPTY: if (load)           state_nxt = SLOT_FULL;
            SLOT_FULL:  if (drain && !load) state_nxt = SLOT_EMPTY;
            default:                        state_nxt = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (load) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/demux8_3_reg.sv
// demux8_3_reg: registered 1-to-8 distributor. One valid/ready source stream
// with a 3-bit destination select feeds eight independent one-entry slots,
// each drained by its own valid/ready handshake. One cycle of latency.
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   source beat present
//   in_ready   out  addressed slot can accept this cycle
//   in_sel     in   destination channel 0..7
//   in_data    in   W-bit payload
//   out_valid  out  bit i: slot i holds a beat
//   out_ready  in   bit i: consumer i accepts slot i
//   out_data   out  slot i payload at [i*W +: W]
//   stat_cnt   out  per-channel delivered-beat counters (only with DEMUX8_STATS_EN)
// Optional feature macro: DEMUX8_STATS_EN
module demux8_3_reg
    import demux8_3_reg_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [W-1:0]           in_data,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic [N_CH*W-1:0]      out_data
`ifdef DEMUX8_STATS_EN
    ,
    output logic [N_CH*STAT_W-1:0] stat_cnt
`endif
);

    logic [N_CH-1:0] load;

    // Depends only on in_sel and out_ready, never on in_valid.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];

    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            load[i] = in_valid & in_ready & (in_sel == i[SEL_W-1:0]);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_slot
        demux_slot #(.W(W)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[g]),
            .ready (out_ready[g]),
            .din   (in_data),
            .valid (out_valid[g]),
            .dout  (out_data[g*W +: W])
        );
    end

`ifdef DEMUX8_STATS_EN
    logic [N_CH-1:0] drain;

    assign drain = out_valid & out_ready;

    // Counters wrap naturally at 2^STAT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (drain[i]) begin
                    stat_cnt[i*STAT_W +: STAT_W] <= stat_cnt[i*STAT_W +: STAT_W] + 1'b1;
                end
            end
        end
    end
`else
    // Statistics disabled: no counter state.
`endif

endmodule
